// File: rtl/im_loader_if.sv
// Byte-stream loader bus: program stream in, instruction-store byte writes and session status out.
interface im_loader_if;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] byte_count;

    modport master (
        output start, base_addr, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, byte_count
    );

    modport slave (
        input  start, base_addr, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err, byte_count
    );
endinterface

// File: rtl/im_loader.sv
// Loads a length-prefixed (big-endian 16-bit) byte program into an instruction store,
// emitting one registered byte write per accepted data byte.
module im_loader #(
    parameter int MAX_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    im_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    state_t      state_r,    state_s;
    logic [31:0] base_r,     base_s;
    logic [15:0] len_r,      len_s;
    logic        wr_en_r,    wr_en_s;
    logic [31:0] wr_addr_r,  wr_addr_s;
    logic [7:0]  wr_data_r,  wr_data_s;
    logic        done_r,     done_s;
    logic        err_r,      err_s;
    logic [15:0] count_r,    count_s;
    logic        in_ready_r, in_ready_s;
    logic        busy_r,     busy_s;
    logic        accept_s;

    // Next-state and next-output logic; in_ready/busy are precomputed from the next state so they stay registered.
    always_comb begin
        state_s   = state_r;
        base_s    = base_r;
        len_s     = len_r;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        done_s    = done_r;
        err_s     = err_r;
        count_s   = count_r;
        accept_s  = bus.in_valid & in_ready_r;

        case (state_r)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_s = LEN_HI;
                    base_s  = bus.base_addr;
                    count_s = 16'd0;
                    done_s  = 1'b0;
                    err_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            LEN_HI: begin
                if (accept_s) begin
                    len_s   = {bus.in_data, 8'h00};
                    state_s = LEN_LO;
                end else begin
                    state_s = state_r;
                end
            end
            LEN_LO: begin
                if (accept_s) begin
                    len_s = {len_r[15:8], bus.in_data};
                    if (len_s == 16'd0) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                    end else if (len_s > MAX_LEN) begin
                        state_s = ERR;
                        err_s   = 1'b1;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            DATA: begin
                if (accept_s) begin
                    // count_r equals the index of this byte: earlier writes are already registered.
                    wr_en_s   = 1'b1;
                    wr_addr_s = base_r + {16'h0000, count_r};
                    wr_data_s = bus.in_data;
                    count_s   = count_r + 16'd1;
                    if (count_s == len_r) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        in_ready_s = (state_s == LEN_HI) || (state_s == LEN_LO) || (state_s == DATA);
        busy_s     = in_ready_s;
    end

    // State and output registers with synchronous reset overriding all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            base_r     <= 32'h0000_0000;
            len_r      <= 16'h0000;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 32'h0000_0000;
            wr_data_r  <= 8'h00;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            count_r    <= 16'h0000;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            base_r     <= base_s;
            len_r      <= len_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            done_r     <= done_s;
            err_r      <= err_s;
            count_r    <= count_s;
            in_ready_r <= in_ready_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.byte_count = count_r;

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 32, max program length in bytes (matches 32-entry byte instruction store).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-005 SHALL have port base_addr  input  32  byte address of first program byte, sampled on accepted start.
REQ-006 SHALL have port in_valid  input  1  source has a byte on in_data.
REQ-007 SHALL have port in_data  input  8  stream byte.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-009 SHALL have port wr_en  output  1  byte write strobe to instruction store.
REQ-010 SHALL have port wr_addr  output  32  byte address of write.
REQ-011 SHALL have port wr_data  output  8  byte to write.
REQ-012 SHALL have port busy  output  1  session in progress (LEN_HI, LEN_LO, DATA).
REQ-013 SHALL have port done  output  1  session completed successfully.
REQ-014 SHALL have port err  output  1  session aborted, length exceeded MAX_BYTES.
REQ-015 SHALL have port byte_count  output  16  bytes written in current/last session.

Function
REQ-016 SHALL implement FSM states IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
REQ-017 Transfer rule: a byte is accepted only in a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA.
REQ-018 IDLE/DONE/ERR + start=1 -> LEN_HI; base_addr latched; byte_count, done, err cleared. start in LEN_HI/LEN_LO/DATA SHALL be ignored.
REQ-019 LEN_HI: accepted byte -> length[15:8], go LEN_LO. LEN_LO: accepted byte -> length[7:0] (big-endian length).
REQ-020 LEN_LO exit: length=0 -> DONE, no writes; length>MAX_BYTES -> ERR, no writes; else -> DATA.
REQ-021 DATA: k-th accepted byte (k from 0) SHALL produce, on the next cycle only, wr_en=1, wr_addr=base+k, wr_data=byte; byte order preserved so byte k=4n is MSB of the big-endian instruction word at base+4n.
REQ-022 Write latency SHALL be exactly 1 cycle after acceptance; back-to-back acceptances SHALL give back-to-back wr_en with no gaps; wr_en=0 in all other cycles.
REQ-023 byte_count SHALL increment in the same cycle wr_en is asserted.
REQ-024 On acceptance of byte length-1, FSM -> DONE; done SHALL rise in the cycle the final wr_en is asserted and hold until next accepted start or rst.
REQ-025 ERR: err=1 held until next accepted start or rst; in_ready=0.
REQ-026 wr_addr arithmetic SHALL be modulo 2^32 (base 0xFFFFFFFE, 4 bytes -> FFFFFFFE, FFFFFFFF, 00000000, 00000001).
REQ-027 in_valid low in any receive state SHALL stall the FSM with no state change and no write.
REQ-028 wr_addr/wr_data SHALL hold last written values while wr_en=0.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE and in_ready, wr_en, wr_addr, wr_data, busy, done, err, byte_count all to 0, overriding start and in_valid in that cycle.
REQ-030 rst mid-session SHALL abort with no further writes; bytes already written are not undone.

Verification
REQ-031 start, base=0x00, stream 00 04 DE AD BE EF, in_valid continuous -> wr_en 4 consecutive cycles at addr 0..3 data DE,AD,BE,EF; done=1 with last write; byte_count=4.
REQ-032 start, stream 00 00 -> DONE, no wr_en, done=1, byte_count=0.
REQ-033 MAX_BYTES=32, stream 00 21 -> err=1, in_ready=0, no wr_en; next start clears err.
REQ-034 base=0xFFFFFFFE, length 4, in_valid toggling 1/0 -> writes at FFFFFFFE, FFFFFFFF, 00000000, 00000001, each 1 cycle after its acceptance, none on stall cycles.
REQ-035 rst asserted after 2 of 8 data bytes -> next cycle all outputs 0, state IDLE; later bytes produce no writes; start pulse while busy ignored (checked earlier in same run).
